// File: rtl/inv_key_schedule_if.sv
// rtl/inv_key_schedule_if.sv - start/key-stream bundle between decrypt controller and inverse key schedule
interface inv_key_schedule_if;
  logic           start;
  logic [127:0]   lastKey;
  logic [127:0]   roundKey;
  logic [3:0]     roundNum;
  logic           keyValid;
  logic           keyReady;
  logic           busy;
  logic           done;
  logic [1407:0]  allKeys;

  modport master (
    output start, lastKey, keyReady,
    input  roundKey, roundNum, keyValid, busy, done, allKeys
  );

  modport slave (
    input  start, lastKey, keyReady,
    output roundKey, roundNum, keyValid, busy, done, allKeys
  );
endinterface

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - AES-128 inverse key schedule, emits round keys 10..0 one per handshake
// Optional INV_KEY_STORE_EN: every emitted key is also captured into allKeys at slot roundNum.
module inv_key_schedule (
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_num_q, round_num_d;
  logic         key_valid_q, key_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] pw, inv;
    pw  = v;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w0, w1, w2, w3, p3, rot, g;
  logic [127:0] prev_key;

  always_comb begin
    w0       = round_key_q[31:0];
    w1       = round_key_q[63:32];
    w2       = round_key_q[95:64];
    w3       = round_key_q[127:96];
    p3       = w3 ^ w2;
    rot      = {p3[23:0], p3[31:24]};
    g        = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
               {rcon(round_num_q), 24'h000000};
    prev_key = {p3, w2 ^ w1, w1 ^ w0, w0 ^ g};
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          round_key_d = bus.lastKey;
          round_num_d = 4'd10;
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (bus.keyReady) begin
          if (round_num_q != 4'd0) begin
            round_key_d = prev_key;
            round_num_d = round_num_q - 4'd1;
          end else begin
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_num_q <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.roundKey = round_key_q;
  assign bus.roundNum = round_num_q;
  assign bus.keyValid = key_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef INV_KEY_STORE_EN
  logic [1407:0] all_keys_q, all_keys_d;
  logic          load_en;

  // A slot is written whenever roundKey is loaded, so it always mirrors the key last shown for that round.
  always_comb begin
    load_en    = ((state_q == IDLE) && bus.start) ||
                 ((state_q == RUN) && bus.keyReady && (round_num_q != 4'd0));
    all_keys_d = all_keys_q;
    if (load_en) all_keys_d[{round_num_d, 7'b0} +: 128] = round_key_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) all_keys_q <= '0;
    else     all_keys_q <= all_keys_d;
  end

  assign bus.allKeys = all_keys_q;
`else
  assign bus.allKeys = '0;
`endif
endmodule
